doorbell_chime_gen: RTL and testbench

//  Upstream stage of the doorbell mux. Turns a push-button press into a two-tone
//  "ding-dong" chime: square-wave tone A for the ding phase, a silent gap, then

---
 rtl/doorbell_pkg.sv | 25 ++
 rtl/doorbell_chime_gen_tone_div.sv | 49 ++++
 rtl/doorbell_chime_gen.sv | 147 ++++++++++++++
 tb/tb_doorbell_chime_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/doorbell_pkg.sv
// Doorbell chime shared definitions: FSM state encoding
// and the counter-width helper used by the chime datapath.
package doorbell_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DING = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONG = 2'd3;

  // A counter for values 0..n-1 never shrinks below one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/doorbell_chime_gen_tone_div.sv
// Square-wave divider: tone toggles every DIV enabled cycles,
// clear forces counter and tone level back to 0.
module tone_div
  import doorbell_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tone_o
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] TOP = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clr_i) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == TOP) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone_o = tone_q;

endmodule

// File: rtl/doorbell_chime_gen.sv
// Ding-gap-dong chime generator feeding the doorbell mux.
// Define CHIME_DEBOUNCE_EN to require DEBOUNCE_CYC stable-high samples per press.
module doorbell_chime_gen
  import doorbell_pkg::*;
#(
  parameter int DIV_A        = 2,
  parameter int DIV_B        = 3,
  parameter int DING_LEN     = 8,
  parameter int GAP_LEN      = 4,
  parameter int DONG_LEN     = 9,
  parameter int DEBOUNCE_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic tone_a,
  output logic tone_b,
  output logic sel,
  output logic busy
);

  localparam int MAXL = max3(DING_LEN, GAP_LEN, DONG_LEN);
  localparam int DW   = cnt_w(MAXL + 1);

  localparam logic [DW-1:0] LD_DING = DW'(DING_LEN - 1);
  localparam logic [DW-1:0] LD_GAP  = DW'(GAP_LEN - 1);
  localparam logic [DW-1:0] LD_DONG = DW'(DONG_LEN - 1);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dur_q, dur_d;
  logic          sel_q, busy_q;
  logic          press;

`ifdef CHIME_DEBOUNCE_EN
  localparam int DBW = cnt_w(DEBOUNCE_CYC + 1);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DEBOUNCE_CYC);
  localparam logic [DBW-1:0] DB_ARM = DBW'(DEBOUNCE_CYC - 1);

  // Run length of consecutive high samples, saturating once accepted.
  logic [DBW-1:0] db_q, db_d;

  always_comb begin
    db_d = '0;
    if (button) begin
      db_d = (db_q == DB_MAX) ? db_q : db_q + 1'b1;
    end
  end

  assign press = button && (db_q == DB_ARM);

  always_ff @(posedge clk) begin
    if (rst) db_q <= '0;
    else     db_q <= db_d;
  end
`else
  logic btn_q;

  assign press = button && !btn_q;

  always_ff @(posedge clk) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= button;
  end
`endif

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d = ST_DING;
          dur_d   = LD_DING;
        end
      end
      ST_DING: begin
        if (dur_q == '0) begin
          state_d = ST_GAP;
          dur_d   = LD_GAP;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (dur_q == '0) begin
          state_d = ST_DONG;
          dur_d   = LD_DONG;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      ST_DONG: begin
        if (dur_q == '0) begin
          state_d = ST_IDLE;
          dur_d   = '0;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        dur_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      sel_q   <= (state_d == ST_DONG);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Dividers run only while staying in their phase; any entry
  // or exit clears them so the tone is 0 outside the phase.
  logic a_clr, b_clr;

  assign a_clr = (state_q != ST_DING) || (state_d != ST_DING);
  assign b_clr = (state_q != ST_DONG) || (state_d != ST_DONG);

  tone_div #(.DIV(DIV_A)) u_div_a (
    .clk    (clk),
    .rst    (rst),
    .en_i   (!a_clr),
    .clr_i  (a_clr),
    .tone_o (tone_a)
  );

  tone_div #(.DIV(DIV_B)) u_div_b (
    .clk    (clk),
    .rst    (rst),
    .en_i   (!b_clr),
    .clr_i  (b_clr),
    .tone_o (tone_b)
  );

  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_doorbell_chime_gen.sv
// Self-checking bench for doorbell_chime_gen against a
// timeline model of the chime (start cycle + offset arithmetic).
module tb_doorbell_chime_gen;

  localparam int DIV_A = 2;
  localparam int DIV_B = 3;
  localparam int DING  = 8;
  localparam int GAP   = 4;
  localparam int DONG  = 9;
  localparam int TOTAL = DING + GAP + DONG;
`ifdef CHIME_DEBOUNCE_EN
  localparam int DB = 3;
`else
  localparam int DB = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button = 1'b0;
  logic tone_a, tone_b, sel, busy;

  always #5 clk = ~clk;

  doorbell_chime_gen dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .tone_a (tone_a),
    .tone_b (tone_b),
    .sel    (sel),
    .busy   (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int start = 0;
  bit active = 0;
  int run = 0;
  logic [3:0] exp_o = 4'b0;

  function automatic bit in_chime(input int m);
    return active && (m >= start) && (m - start < TOTAL);
  endfunction

  // {busy, sel, tone_a, tone_b} expected for edge n.
  function automatic logic [3:0] model_out(input int n);
    int i;
    int j;
    if (!in_chime(n)) return 4'b0000;
    i = n - start;
    if (i < DING) return {2'b10, 1'((i / DIV_A) % 2), 1'b0};
    if (i < DING + GAP) return 4'b1000;
    j = i - DING - GAP;
    return {2'b11, 1'b0, 1'((j / DIV_B) % 2)};
  endfunction

  task automatic tick(input logic b, input logic r);
    button = b;
    rst    = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      active = 0;
      run    = 0;
    end else begin
      run = b ? run + 1 : 0;
      if (b && run == DB && !in_chime(cyc - 1)) begin
        active = 1;
        start  = cyc;
      end
    end
    exp_o = model_out(cyc);
    #1;
  endtask

  function automatic logic [3:0] obs();
    return {busy, sel, tone_a, tone_b};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1);
      n_tests++;
      if (obs() !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b exp=0000",
                 cyc, obs());
      end
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_single();
    logic [7:0] ta;
    logic [8:0] tb;
    int nbusy;
    int nsel;
    ta = '0;
    tb = '0;
    nbusy = 0;
    nsel = 0;
    for (int i = 0; i < DB; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < TOTAL + 6; i++) begin
      if (i < DING) ta[i] = tone_a;
      if (i >= DING + GAP && i < TOTAL)
        tb[i - DING - GAP] = tone_b;
      nbusy += int'(busy);
      nsel  += int'(sel);
      n_tests++;
      if (obs() !== exp_o) begin
        n_fail++;
        $display("FAIL single cyc=%0d got=%b exp=%b",
                 cyc, obs(), exp_o);
      end
      tick(1'b0, 1'b0);
    end
    n_tests++;
    if (ta !== 8'b1100_1100) begin
      n_fail++;
      $display("FAIL ding_seq got=%b exp=11001100", ta);
    end
    n_tests++;
    if (tb !== 9'b000_111_000) begin
      n_fail++;
      $display("FAIL dong_seq got=%b exp=000111000", tb);
    end
    n_tests++;
    if (nbusy != TOTAL || nsel != DONG) begin
      n_fail++;
      $display("FAIL lengths busy=%0d sel=%0d exp=%0d/%0d",
               nbusy, nsel, TOTAL, DONG);
    end
  endtask

  task automatic test_ignore();
    int nbusy;
    nbusy = 0;
    for (int i = 0; i < DB; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < TOTAL + 5; i++) begin
      nbusy += int'(busy);
      n_tests++;
      if (obs() !== exp_o) begin
        n_fail++;
        $display("FAIL ignore cyc=%0d got=%b exp=%b",
                 cyc, obs(), exp_o);
      end
      tick((i >= 4 && i < 4 + DB), 1'b0);
    end
    n_tests++;
    if (nbusy != TOTAL) begin
      n_fail++;
      $display("FAIL ignore_len got=%0d exp=%0d", nbusy, TOTAL);
    end
  endtask

  task automatic test_hold();
    int rises;
    logic pb;
    rises = 0;
    pb = busy;
    for (int i = 0; i < 60; i++) begin
      tick(i < 40 || (i >= 44 && i < 44 + DB), 1'b0);
      if (busy && !pb) rises++;
      pb = busy;
      n_tests++;
      if (obs() !== exp_o) begin
        n_fail++;
        $display("FAIL hold cyc=%0d got=%b exp=%b",
                 cyc, obs(), exp_o);
      end
    end
    n_tests++;
    if (rises != 2) begin
      n_fail++;
      $display("FAIL hold_chimes got=%0d exp=2", rises);
    end
    for (int i = 0; i < TOTAL; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < DB; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < DING + GAP + 3; i++) tick(1'b0, 1'b0);
    n_tests++;
    if (sel !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_sel got=%b exp=1", sel);
    end
    tick(1'b0, 1'b1);
    n_tests++;
    if (obs() !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid got=%b exp=0000", obs());
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    for (int i = 0; i < TOTAL + 4 + DB; i++) begin
      tick(i < DB, 1'b0);
      n_tests++;
      if (obs() !== exp_o) begin
        n_fail++;
        $display("FAIL rst_resume cyc=%0d got=%b exp=%b",
                 cyc, obs(), exp_o);
      end
    end
  endtask

  task automatic test_latency();
    int lat;
    int k;
    lat = -1;
    k = 0;
`ifdef CHIME_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      tick(i < 2, 1'b0);
      n_tests++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL short_pulse cyc=%0d busy=%b exp=0",
                 cyc, busy);
      end
    end
`endif
    while (lat < 0 && k < 10) begin
      tick(1'b1, 1'b0);
      if (busy) lat = k;
      k++;
    end
    n_tests++;
    if (lat != DB - 1) begin
      n_fail++;
      $display("FAIL latency got=%0d exp=%0d", lat, DB - 1);
    end
    for (int i = 0; i < TOTAL + 2; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic b;
    logic r;
    b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      r = ($urandom_range(0, 60) == 0);
      tick(b, r);
      n_tests++;
      if (obs() !== exp_o) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b exp=%b",
                 cyc, obs(), exp_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignore();
    test_hold();
    test_rst_mid();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
